// File: rtl/ctrl_pkg.sv
// Shared control-bundle type and encodings for the 5-stage pipeline control path.
package ctrl_pkg;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [4:0] alu_control;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_hazard.sv
// Combinational hazard resolution: redirect, load-use stall and EX operand forwarding.
module ctrl_hazard
    import ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              ex_valid,
    input  logic              ex_branch,
    input  logic              ex_jal,
    input  logic              ex_jalr,
    input  logic              ex_btaken,
    input  logic              ex_reg_write,
    input  logic [1:0]        ex_result_src,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_valid,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        pc_src,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              ex_bubble
);

    logic redirect;
    logic load_use;
    logic mem_fwd_ok;
    logic wb_fwd_ok;

    assign redirect = ex_valid & ((ex_branch & ex_btaken) | ex_jal | ex_jalr);

    assign load_use = ex_valid & (ex_result_src == RES_LOAD) & ex_reg_write
                    & (ex_rd != '0) & id_valid
                    & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    assign mem_fwd_ok = mem_valid & mem_reg_write & (mem_rd != '0);
    assign wb_fwd_ok  = wb_valid & wb_reg_write & (wb_rd != '0);

    // A redirect discards the stalled ID instruction anyway, so it suppresses the stall.
    always_comb begin
        pc_src    = PC_PLUS4;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        flush_d   = 1'b0;
        ex_bubble = 1'b0;
        if (redirect) begin
            pc_src    = ex_jalr ? PC_JALR : PC_TARGET;
            flush_d   = 1'b1;
            ex_bubble = 1'b1;
        end else if (load_use) begin
            stall_f   = 1'b1;
            stall_d   = 1'b1;
            ex_bubble = 1'b1;
        end
    end

    always_comb begin
        forward_a = FWD_RF;
        forward_b = FWD_RF;
        if (mem_fwd_ok && (mem_rd == ex_rs1))
            forward_a = FWD_MEM;
        else if (wb_fwd_ok && (wb_rd == ex_rs1))
            forward_a = FWD_WB;
        if (mem_fwd_ok && (mem_rd == ex_rs2))
            forward_b = FWD_MEM;
        else if (wb_fwd_ok && (wb_rd == ex_rs2))
            forward_b = FWD_WB;
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Carries the decoded control bundle through ID/EX, EX/MEM and MEM/WB and exposes hazard controls.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_reg_write,
    input  logic              id_mem_write,
    input  logic              id_branch,
    input  logic              id_jal,
    input  logic              id_jalr,
    input  logic              id_alu_src_b,
    input  logic [1:0]        id_result_src,
    input  logic [1:0]        id_alu_src_a,
    input  logic [4:0]        id_alu_control,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_btaken,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_write,
    output logic [1:0]        ex_result_src,
    output logic [1:0]        ex_alu_src_a,
    output logic              ex_alu_src_b,
    output logic [4:0]        ex_alu_control,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic              mem_valid,
    output logic              mem_reg_write,
    output logic              mem_mem_write,
    output logic [1:0]        mem_result_src,
    output logic [REG_AW-1:0] mem_rd,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [1:0]        wb_result_src,
    output logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        pc_src,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b
);

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;
    logic  ex_bubble;

    assign id_ctrl = '{
        reg_write:   id_reg_write,
        mem_write:   id_mem_write,
        branch:      id_branch,
        jal:         id_jal,
        jalr:        id_jalr,
        alu_src_b:   id_alu_src_b,
        result_src:  id_result_src,
        alu_src_a:   id_alu_src_a,
        alu_control: id_alu_control
    };

    assign ex_reg_write   = ex_ctrl.reg_write;
    assign ex_mem_write   = ex_ctrl.mem_write;
    assign ex_result_src  = ex_ctrl.result_src;
    assign ex_alu_src_a   = ex_ctrl.alu_src_a;
    assign ex_alu_src_b   = ex_ctrl.alu_src_b;
    assign ex_alu_control = ex_ctrl.alu_control;

    ctrl_hazard #(.REG_AW(REG_AW)) u_hazard (
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .ex_valid      (ex_valid),
        .ex_branch     (ex_ctrl.branch),
        .ex_jal        (ex_ctrl.jal),
        .ex_jalr       (ex_ctrl.jalr),
        .ex_btaken     (ex_btaken),
        .ex_reg_write  (ex_ctrl.reg_write),
        .ex_result_src (ex_ctrl.result_src),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .ex_rd         (ex_rd),
        .mem_valid     (mem_valid),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .pc_src        (pc_src),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .flush_d       (flush_d),
        .forward_a     (forward_a),
        .forward_b     (forward_b),
        .ex_bubble     (ex_bubble)
    );

    // Bubbles are fully zeroed so later stages can copy EX/MEM blindly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid       <= 1'b0;
            ex_ctrl        <= CTRL_BUBBLE;
            ex_rs1         <= '0;
            ex_rs2         <= '0;
            ex_rd          <= '0;
            mem_valid      <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_result_src <= '0;
            mem_rd         <= '0;
            wb_valid       <= 1'b0;
            wb_reg_write   <= 1'b0;
            wb_result_src  <= '0;
            wb_rd          <= '0;
        end else begin
            if (ex_bubble || !id_valid) begin
                ex_valid <= 1'b0;
                ex_ctrl  <= CTRL_BUBBLE;
                ex_rs1   <= '0;
                ex_rs2   <= '0;
                ex_rd    <= '0;
            end else begin
                ex_valid <= 1'b1;
                ex_ctrl  <= id_ctrl;
                ex_rs1   <= id_rs1;
                ex_rs2   <= id_rs2;
                ex_rd    <= id_rd;
            end
            mem_valid      <= ex_valid;
            mem_reg_write  <= ex_ctrl.reg_write;
            mem_mem_write  <= ex_ctrl.mem_write;
            mem_result_src <= ex_ctrl.result_src;
            mem_rd         <= ex_rd;
            wb_valid       <= mem_valid;
            wb_reg_write   <= mem_reg_write;
            wb_result_src  <= mem_result_src;
            wb_rd          <= mem_rd;
        end
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed hazard scenarios plus randomized traffic checked against a pipeline-slot model.
module tb_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_reg_write, id_mem_write, id_branch, id_jal, id_jalr, id_alu_src_b;
    logic [1:0] id_result_src, id_alu_src_a;
    logic [4:0] id_alu_control, id_rs1, id_rs2, id_rd;
    logic       ex_btaken;
    logic       ex_valid, ex_reg_write, ex_mem_write, ex_alu_src_b;
    logic [1:0] ex_result_src, ex_alu_src_a;
    logic [4:0] ex_alu_control, ex_rs1, ex_rs2, ex_rd;
    logic       mem_valid, mem_reg_write, mem_mem_write;
    logic [1:0] mem_result_src;
    logic [4:0] mem_rd;
    logic       wb_valid, wb_reg_write;
    logic [1:0] wb_result_src;
    logic [4:0] wb_rd;
    logic [1:0] pc_src, forward_a, forward_b;
    logic       stall_f, stall_d, flush_d;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    ctrl_pipe #(.REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_reg_write(id_reg_write), .id_mem_write(id_mem_write),
        .id_branch(id_branch), .id_jal(id_jal), .id_jalr(id_jalr), .id_alu_src_b(id_alu_src_b),
        .id_result_src(id_result_src), .id_alu_src_a(id_alu_src_a), .id_alu_control(id_alu_control),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_btaken(ex_btaken),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
        .ex_result_src(ex_result_src), .ex_alu_src_a(ex_alu_src_a), .ex_alu_src_b(ex_alu_src_b),
        .ex_alu_control(ex_alu_control), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
        .mem_result_src(mem_result_src), .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_result_src(wb_result_src), .wb_rd(wb_rd),
        .pc_src(pc_src), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .forward_a(forward_a), .forward_b(forward_b)
    );

    // Reference model: one instruction record per downstream pipeline slot.
    typedef struct packed {
        bit       v, rw, mw, br, jal, jalr, asb;
        bit [1:0] rs, asa;
        bit [4:0] alu, rs1, rs2, rd;
    } ins_t;

    ins_t m_ex, m_mem, m_wb;
    bit   m_bub;

    function automatic ins_t cur_id();
        ins_t t;
        t = '{v: id_valid, rw: id_reg_write, mw: id_mem_write, br: id_branch, jal: id_jal,
              jalr: id_jalr, asb: id_alu_src_b, rs: id_result_src, asa: id_alu_src_a,
              alu: id_alu_control, rs1: id_rs1, rs2: id_rs2, rd: id_rd};
        return t;
    endfunction

    function automatic bit e_redirect();
        return m_ex.v && ((m_ex.br && ex_btaken) || m_ex.jal || m_ex.jalr);
    endfunction

    function automatic bit e_loaduse();
        return m_ex.v && m_ex.rs == 2'd1 && m_ex.rw && m_ex.rd != 0 && id_valid
            && (m_ex.rd == id_rs1 || m_ex.rd == id_rs2);
    endfunction

    function automatic bit [1:0] e_fwd(input bit [4:0] rs);
        if (m_mem.v && m_mem.rw && m_mem.rd != 0 && m_mem.rd == rs) return 2'd2;
        if (m_wb.v && m_wb.rw && m_wb.rd != 0 && m_wb.rd == rs) return 2'd1;
        return 2'd0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ex = '0; m_mem = '0; m_wb = '0;
        end else begin
            m_bub = e_redirect() || e_loaduse() || !id_valid;
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = m_bub ? '0 : cur_id();
        end
    end

    task automatic set_id(input bit v, rw, mw, br, jl, jr, input bit [1:0] rs,
                          input bit [4:0] r1, r2, rd);
        id_valid = v; id_reg_write = rw; id_mem_write = mw; id_branch = br;
        id_jal = jl; id_jalr = jr; id_result_src = rs;
        id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_alu_control = v ? 5'($urandom) : 5'd0;
        id_alu_src_a   = v ? 2'($urandom) : 2'd0;
        id_alu_src_b   = v ? 1'($urandom) : 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            ex_btaken = 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_id(1, 1, 0, 0, 0, 0, 0, 0, 0, 5'(i + 1));
        end
        @(negedge clk);
        #1;
        checks++; if ({ex_valid, mem_valid, wb_valid} !== 3'b111)
            $display("FAIL inflight_valid: got %b expected 111", {ex_valid, mem_valid, wb_valid});
        else passed++;
        rst_n = 0;
        set_id(1, 1, 0, 0, 0, 0, 1, 3, 3, 3);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            checks++; if ({ex_valid, mem_valid, wb_valid} !== 3'b000)
                $display("FAIL reset_valid: got %b expected 000", {ex_valid, mem_valid, wb_valid});
            else passed++;
            checks++; if ({pc_src, stall_f, stall_d, flush_d, forward_a, forward_b,
                           ex_reg_write, ex_rd, mem_reg_write, mem_rd, wb_reg_write, wb_rd} !== '0)
                $display("FAIL reset_outputs: got %h expected 0", {pc_src, stall_f, stall_d,
                         flush_d, forward_a, forward_b, ex_reg_write, ex_rd, mem_reg_write,
                         mem_rd, wb_reg_write, wb_rd});
            else passed++;
        end
        rst_n = 1;
        @(negedge clk);
        #1;
        checks++; if ({ex_valid, ex_rd, mem_valid} !== {1'b1, 5'd3, 1'b0})
            $display("FAIL reset_restart: got %b/%0d/%b expected 1/3/0", ex_valid, ex_rd, mem_valid);
        else passed++;
    endtask

    task automatic test_load_use();
        @(negedge clk); set_id(1, 1, 0, 0, 0, 0, 1, 2, 0, 5);
        @(negedge clk); set_id(1, 1, 0, 0, 0, 0, 0, 5, 1, 6);
        #1;
        checks++; if ({stall_f, stall_d, flush_d, pc_src} !== 5'b11000)
            $display("FAIL lu_stall: got %b expected 11000", {stall_f, stall_d, flush_d, pc_src});
        else passed++;
        @(negedge clk);
        #1;
        checks++; if ({ex_valid, stall_f, stall_d, mem_valid} !== 4'b0001)
            $display("FAIL lu_bubble: got %b expected 0001", {ex_valid, stall_f, stall_d, mem_valid});
        else passed++;
        @(negedge clk); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if ({ex_valid, ex_rd} !== {1'b1, 5'd6})
            $display("FAIL lu_dep_in_ex: got %b/%0d expected 1/6", ex_valid, ex_rd);
        else passed++;
        checks++; if ({forward_a, forward_b} !== 4'b0100)
            $display("FAIL lu_forward: got %b expected 0100", {forward_a, forward_b});
        else passed++;
    endtask

    task automatic test_forward_priority();
        @(negedge clk); set_id(1, 1, 0, 0, 0, 0, 0, 1, 2, 3);
        @(negedge clk); set_id(1, 1, 0, 0, 0, 0, 0, 1, 2, 3);
        @(negedge clk); set_id(1, 1, 0, 0, 0, 0, 0, 3, 3, 4);
        #1;
        checks++; if ({stall_f, forward_a, forward_b} !== 5'b00000)
            $display("FAIL fp_pre: got %b expected 00000", {stall_f, forward_a, forward_b});
        else passed++;
        @(negedge clk); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if ({forward_a, forward_b} !== 4'b1010)
            $display("FAIL fp_mem_wins: got %b expected 1010", {forward_a, forward_b});
        else passed++;
        checks++; if ({ex_rd, wb_valid, wb_rd} !== {5'd4, 1'b1, 5'd3})
            $display("FAIL fp_stages: got %h expected %h", {ex_rd, wb_valid, wb_rd}, {5'd4, 1'b1, 5'd3});
        else passed++;
    endtask

    task automatic test_branch();
        @(negedge clk); set_id(1, 0, 0, 1, 0, 0, 0, 1, 2, 0);
        @(negedge clk); set_id(1, 1, 0, 0, 0, 0, 0, 0, 0, 7); ex_btaken = 1;
        #1;
        checks++; if ({pc_src, flush_d, stall_f, stall_d} !== 5'b01100)
            $display("FAIL br_taken: got %b expected 01100", {pc_src, flush_d, stall_f, stall_d});
        else passed++;
        @(negedge clk); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex_btaken = 0;
        #1;
        checks++; if ({ex_valid, mem_valid, pc_src} !== 4'b0100)
            $display("FAIL br_flushed: got %b expected 0100", {ex_valid, mem_valid, pc_src});
        else passed++;
        @(negedge clk); set_id(1, 0, 0, 1, 0, 0, 0, 1, 2, 0);
        @(negedge clk); set_id(1, 1, 0, 0, 0, 0, 0, 0, 0, 7); ex_btaken = 0;
        #1;
        checks++; if ({pc_src, flush_d} !== 3'b000)
            $display("FAIL br_not_taken: got %b expected 000", {pc_src, flush_d});
        else passed++;
        @(negedge clk); set_id(1, 1, 0, 0, 1, 0, 2, 0, 0, 1);
        #1;
        checks++; if ({ex_valid, ex_rd} !== {1'b1, 5'd7})
            $display("FAIL br_fallthrough: got %b/%0d expected 1/7", ex_valid, ex_rd);
        else passed++;
        @(negedge clk); set_id(1, 1, 0, 0, 1, 0, 2, 0, 0, 1);
        #1;
        checks++; if ({pc_src, flush_d} !== 3'b011)
            $display("FAIL jal_redirect: got %b expected 011", {pc_src, flush_d});
        else passed++;
        @(negedge clk); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if ({ex_valid, pc_src, flush_d} !== 4'b0000)
            $display("FAIL jal_back_to_back: got %b expected 0000", {ex_valid, pc_src, flush_d});
        else passed++;
    endtask

    task automatic test_jalr_load_use();
        @(negedge clk); set_id(1, 1, 0, 0, 0, 1, 1, 1, 0, 5);
        @(negedge clk); set_id(1, 1, 0, 0, 0, 0, 0, 5, 5, 6);
        #1;
        checks++; if ({pc_src, flush_d, stall_f, stall_d} !== 5'b10100)
            $display("FAIL jalr_lu: got %b expected 10100", {pc_src, flush_d, stall_f, stall_d});
        else passed++;
        @(negedge clk); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if ({ex_valid, mem_valid} !== 2'b01)
            $display("FAIL jalr_flushed: got %b expected 01", {ex_valid, mem_valid});
        else passed++;
    endtask

    task automatic test_x0();
        @(negedge clk); set_id(1, 1, 0, 0, 0, 0, 1, 2, 0, 0);
        @(negedge clk); set_id(1, 1, 0, 0, 0, 0, 0, 0, 0, 6);
        #1;
        checks++; if ({stall_f, stall_d, flush_d} !== 3'b000)
            $display("FAIL x0_no_stall: got %b expected 000", {stall_f, stall_d, flush_d});
        else passed++;
        @(negedge clk); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if ({ex_valid, mem_valid, forward_a, forward_b} !== 6'b110000)
            $display("FAIL x0_no_forward: got %b expected 110000", {ex_valid, mem_valid, forward_a, forward_b});
        else passed++;
    endtask

    task automatic test_random();
        bit       hold = 0;
        int       kind;
        bit [4:0] r1, r2, rd;
        logic [27:0] e_exv;
        logic [9:0]  e_memv;
        logic [8:0]  e_wbv, e_ctl;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 59) != 0);
            if (!hold) begin
                kind = $urandom_range(0, 9);
                r1 = 5'($urandom_range(0, 3));
                r2 = 5'($urandom_range(0, 3));
                rd = 5'($urandom_range(0, 3));
                case (kind)
                    0, 1, 2: set_id(1, 1, 0, 0, 0, 0, 1, r1, 0, rd);
                    3:       set_id(1, 0, 0, 1, 0, 0, 0, r1, r2, 0);
                    4:       set_id(1, 1, 0, 0, 1, 0, 2, 0, 0, rd);
                    5:       set_id(1, 1, 0, 0, 0, 1, 2, r1, 0, rd);
                    6:       set_id(1, 0, 1, 0, 0, 0, 0, r1, r2, 0);
                    default: set_id(1, 1, 0, 0, 0, 0, 0, r1, r2, rd);
                endcase
                if ($urandom_range(0, 7) == 0) set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            end
            ex_btaken = 1'($urandom);
            #1;
            e_exv  = {m_ex.v, m_ex.rw, m_ex.mw, m_ex.rs, m_ex.asa, m_ex.asb, m_ex.alu,
                      m_ex.rs1, m_ex.rs2, m_ex.rd};
            e_memv = {m_mem.v, m_mem.rw, m_mem.mw, m_mem.rs, m_mem.rd};
            e_wbv  = {m_wb.v, m_wb.rw, m_wb.rs, m_wb.rd};
            e_ctl  = {(!e_redirect()) ? 2'd0 : (m_ex.jalr ? 2'd2 : 2'd1),
                      e_loaduse() && !e_redirect(), e_loaduse() && !e_redirect(),
                      e_redirect(), e_fwd(m_ex.rs1), e_fwd(m_ex.rs2)};
            checks++; if ({ex_valid, ex_reg_write, ex_mem_write, ex_result_src, ex_alu_src_a,
                           ex_alu_src_b, ex_alu_control, ex_rs1, ex_rs2, ex_rd} !== e_exv)
                $display("FAIL rnd_ex cycle %0d: got %h expected %h", i, {ex_valid, ex_reg_write,
                         ex_mem_write, ex_result_src, ex_alu_src_a, ex_alu_src_b, ex_alu_control,
                         ex_rs1, ex_rs2, ex_rd}, e_exv);
            else passed++;
            checks++; if ({mem_valid, mem_reg_write, mem_mem_write, mem_result_src, mem_rd} !== e_memv)
                $display("FAIL rnd_mem cycle %0d: got %h expected %h", i, {mem_valid, mem_reg_write,
                         mem_mem_write, mem_result_src, mem_rd}, e_memv);
            else passed++;
            checks++; if ({wb_valid, wb_reg_write, wb_result_src, wb_rd} !== e_wbv)
                $display("FAIL rnd_wb cycle %0d: got %h expected %h", i,
                         {wb_valid, wb_reg_write, wb_result_src, wb_rd}, e_wbv);
            else passed++;
            checks++; if ({pc_src, stall_f, stall_d, flush_d, forward_a, forward_b} !== e_ctl)
                $display("FAIL rnd_hazard cycle %0d: got %b expected %b", i,
                         {pc_src, stall_f, stall_d, flush_d, forward_a, forward_b}, e_ctl);
            else passed++;
            hold = rst_n && e_loaduse() && !e_redirect();
        end
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        ex_btaken = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        test_reset();
        idle(3);
        test_load_use();
        idle(3);
        test_forward_priority();
        idle(3);
        test_branch();
        idle(3);
        test_jalr_load_use();
        idle(3);
        test_x0();
        idle(3);
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
